// File: rtl/flash_seq_pkg.sv
// Shared definitions for the parallel-flash access sequencer and its command decoder.
package flash_seq_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_RESET = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_RSTP,
        ST_RESP
    } state_e;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/flash_seq_timer.sv
// Loadable down-counter; done_c flags the last cycle of a phase loaded with N (N >= 1).
module flash_seq_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/flash_access_sequencer.sv
// Parallel-flash timing engine: turns one decoded read/write/reset command into
// nEN/nRE/nWE/nReset strobe sequences and returns read data or a completion pulse.
module flash_access_sequencer
    import flash_seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 3,
    parameter int unsigned T_HOLD  = 1,
    parameter int unsigned T_RESET = 8
) (
    input  logic              SCK,
    input  logic              bi_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              nEN,
    output logic              nRE,
    output logic              nWE,
    output logic              nReset,
    output logic [ADDR_W-1:0] Addr,
    inout  wire  [DATA_W-1:0] IO
);

    localparam int unsigned T_MAX = max2(max2(T_SETUP, T_PULSE), max2(T_HOLD, T_RESET));
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);

    if (T_SETUP == 0 || T_PULSE == 0 || T_HOLD == 0 || T_RESET == 0) begin : g_bad_timing
        $error("flash_access_sequencer: every T_* timing parameter must be >= 1");
    end

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              nen_q, nen_d;
    logic              nre_q, nre_d;
    logic              nwe_q, nwe_d;
    logic              nreset_q, nreset_d;
    logic              io_oe_q, io_oe_d;
    logic [DATA_W-1:0] io_out_q, io_out_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_done_c;

    flash_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (SCK),
        .rst      (bi_rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done_c   (tmr_done_c)
    );

    assign cmd_ready = (state_q == ST_IDLE) && !bi_rst;
    assign busy      = (state_q != ST_IDLE);

    // Next-state and next-output logic; every pin value is computed one cycle ahead and registered.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        nen_d       = nen_q;
        nre_d       = nre_q;
        nwe_d       = nwe_q;
        nreset_d    = nreset_q;
        io_oe_d     = io_oe_q;
        io_out_d    = io_out_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d = op_e'(cmd_op);
                    unique case (op_e'(cmd_op))
                        OP_READ, OP_WRITE: begin
                            state_d  = ST_SETUP;
                            tmr_load = 1'b1;
                            tmr_val  = CNT_W'(T_SETUP);
                            addr_d   = cmd_addr;
                            nen_d    = 1'b0;
                            if (op_e'(cmd_op) == OP_WRITE) begin
                                io_oe_d  = 1'b1;
                                io_out_d = cmd_wdata;
                            end
                        end
                        OP_RESET: begin
                            state_d  = ST_RSTP;
                            tmr_load = 1'b1;
                            tmr_val  = CNT_W'(T_RESET);
                            nreset_d = 1'b0;
                        end
                        default: begin
                            state_d     = ST_RESP;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                        end
                    endcase
                end
            end
            ST_SETUP: begin
                if (tmr_done_c) begin
                    state_d  = ST_PULSE;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_PULSE);
                    nre_d    = (op_q != OP_READ);
                    nwe_d    = (op_q != OP_WRITE);
                end
            end
            ST_PULSE: begin
                if (tmr_done_c) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_HOLD);
                    nre_d    = 1'b1;
                    nwe_d    = 1'b1;
                    if (op_q == OP_READ) begin
                        rdata_d = IO;
                    end
                end
            end
            ST_HOLD: begin
                if (tmr_done_c) begin
                    state_d     = ST_RESP;
                    nen_d       = 1'b1;
                    io_oe_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_RSTP: begin
                if (tmr_done_c) begin
                    state_d     = ST_RESP;
                    nreset_d    = 1'b1;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SCK) begin
        if (bi_rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_READ;
            addr_q      <= '0;
            nen_q       <= 1'b1;
            nre_q       <= 1'b1;
            nwe_q       <= 1'b1;
            nreset_q    <= 1'b1;
            io_oe_q     <= 1'b0;
            io_out_q    <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            nen_q       <= nen_d;
            nre_q       <= nre_d;
            nwe_q       <= nwe_d;
            nreset_q    <= nreset_d;
            io_oe_q     <= io_oe_d;
            io_out_q    <= io_out_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign nEN       = nen_q;
    assign nRE       = nre_q;
    assign nWE       = nwe_q;
    assign nReset    = nreset_q;
    assign Addr      = addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rdata_q;
    assign IO        = io_oe_q ? io_out_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_flash_access_sequencer.sv
// Directed bench for flash_access_sequencer: cycle-exact strobe, response and abort behaviour.
module tb_flash_access_sequencer;

    logic        SCK = 1'b0;
    logic        bi_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        nEN;
    logic        nRE;
    logic        nWE;
    logic        nReset;
    logic [15:0] Addr;
    wire  [7:0]  io_bus;
    logic [7:0]  flash_q;

    int checks   = 0;
    int failures = 0;

    flash_access_sequencer dut (
        .SCK       (SCK),
        .bi_rst    (bi_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .nEN       (nEN),
        .nRE       (nRE),
        .nWE       (nWE),
        .nReset    (nReset),
        .Addr      (Addr),
        .IO        (io_bus)
    );

    // Flash model: drives its data only while selected and read-strobed.
    assign io_bus = (!nEN && !nRE) ? flash_q : 8'hzz;

    always #5 SCK = ~SCK;

    // Pin/status vector: {nEN, nRE, nWE, nReset, rsp_valid, rsp_err, busy, cmd_ready}
    wire [7:0] status = {nEN, nRE, nWE, nReset, rsp_valid, rsp_err, busy, cmd_ready};

    task automatic tick();
        @(posedge SCK);
        #1;
    endtask

    task automatic accept(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d);
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        bi_rst    = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = 16'h0;
        cmd_wdata = 8'h0;
        flash_q   = 8'h00;
        tick();
        tick();
        checks++;
        if (status !== 8'hF0) begin
            failures++;
            $display("FAIL reset_pins got=%b want=%b", status, 8'hF0);
        end
        checks++;
        if (Addr !== 16'h0 || rsp_rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_regs addr=%h rdata=%h want addr=0000 rdata=00", Addr, rsp_rdata);
        end
        bi_rst = 1'b0;
        #1;
        checks++;
        if (status !== 8'hF1) begin
            failures++;
            $display("FAIL reset_release got=%b want=%b", status, 8'hF1);
        end
        tick();
    endtask

    task automatic test_write();
        logic [7:0] exp;
        accept(2'b01, 16'h1234, 8'hA5);
        for (int c = 1; c <= 8; c++) begin
            exp = {!(c >= 1 && c <= 6), 1'b1, !(c >= 3 && c <= 5), 1'b1,
                   c == 7, 1'b0, c <= 7, c >= 8};
            checks++;
            if (status !== exp) begin
                failures++;
                $display("FAIL write_pins cyc=%0d got=%b want=%b", c, status, exp);
            end
            checks++;
            if (Addr !== 16'h1234) begin
                failures++;
                $display("FAIL write_addr cyc=%0d got=%h want=1234", c, Addr);
            end
            checks++;
            if ((c <= 6) ? (io_bus !== 8'hA5) : (io_bus === 8'hA5)) begin
                failures++;
                $display("FAIL write_io cyc=%0d got=%h want %s", c, io_bus,
                         (c <= 6) ? "A5" : "released");
            end
            if (c == 7) begin
                checks++;
                if (rsp_rdata !== 8'h00) begin
                    failures++;
                    $display("FAIL write_rdata_kept got=%h want=00", rsp_rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_read();
        logic [7:0] exp;
        flash_q = 8'h3C;
        accept(2'b00, 16'h00FF, 8'h5A);
        for (int c = 1; c <= 8; c++) begin
            exp = {!(c >= 1 && c <= 6), !(c >= 3 && c <= 5), 1'b1, 1'b1,
                   c == 7, 1'b0, c <= 7, c >= 8};
            checks++;
            if (status !== exp) begin
                failures++;
                $display("FAIL read_pins cyc=%0d got=%b want=%b", c, status, exp);
            end
            checks++;
            if (Addr !== 16'h00FF) begin
                failures++;
                $display("FAIL read_addr cyc=%0d got=%h want=00FF", c, Addr);
            end
            checks++;
            if ((c >= 3 && c <= 5) ? (io_bus !== 8'h3C)
                                   : (io_bus === 8'hA5 || io_bus === 8'h5A)) begin
                failures++;
                $display("FAIL read_io cyc=%0d got=%h want %s", c, io_bus,
                         (c >= 3 && c <= 5) ? "3C from flash" : "not driven by sequencer");
            end
            if (c == 7) begin
                checks++;
                if (rsp_rdata !== 8'h3C) begin
                    failures++;
                    $display("FAIL read_rdata got=%h want=3C", rsp_rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_op();
        logic [7:0] exp;
        accept(2'b10, 16'h0ABC, 8'h11);
        for (int c = 1; c <= 10; c++) begin
            exp = {1'b1, 1'b1, 1'b1, !(c >= 1 && c <= 8),
                   c == 9, 1'b0, c <= 9, c >= 10};
            checks++;
            if (status !== exp) begin
                failures++;
                $display("FAIL rstop_pins cyc=%0d got=%b want=%b", c, status, exp);
            end
            checks++;
            if (Addr !== 16'h00FF) begin
                failures++;
                $display("FAIL rstop_addr cyc=%0d got=%h want=00FF", c, Addr);
            end
            if (c == 9) begin
                checks++;
                if (rsp_rdata !== 8'h3C) begin
                    failures++;
                    $display("FAIL rstop_rdata_kept got=%h want=3C", rsp_rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_reserved();
        logic [7:0] exp;
        accept(2'b11, 16'h0F0F, 8'h77);
        for (int c = 1; c <= 2; c++) begin
            exp = {1'b1, 1'b1, 1'b1, 1'b1, c == 1, c == 1, c == 1, c == 2};
            checks++;
            if (status !== exp) begin
                failures++;
                $display("FAIL rsvd_pins cyc=%0d got=%b want=%b", c, status, exp);
            end
            checks++;
            if (Addr !== 16'h00FF || io_bus === 8'h77 || rsp_rdata !== 8'h3C) begin
                failures++;
                $display("FAIL rsvd_side cyc=%0d addr=%h io=%h rdata=%h want addr=00FF io!=77 rdata=3C",
                         c, Addr, io_bus, rsp_rdata);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        int d;
        flash_q   = 8'h96;
        cmd_op    = 2'b01;
        cmd_addr  = 16'h0AAA;
        cmd_wdata = 8'h5A;
        cmd_valid = 1'b1;
        tick();
        cmd_op    = 2'b00;
        cmd_addr  = 16'h0BBB;
        cmd_wdata = 8'hFF;
        for (int c = 1; c <= 16; c++) begin
            if (c <= 8) begin
                exp = {!(c <= 6), 1'b1, !(c >= 3 && c <= 5), 1'b1,
                       c == 7, 1'b0, c <= 7, c == 8};
            end else begin
                d   = c - 8;
                exp = {!(d <= 6), !(d >= 3 && d <= 5), 1'b1, 1'b1,
                       d == 7, 1'b0, d <= 7, d == 8};
            end
            checks++;
            if (status !== exp) begin
                failures++;
                $display("FAIL b2b_pins cyc=%0d got=%b want=%b", c, status, exp);
            end
            checks++;
            if (Addr !== ((c <= 8) ? 16'h0AAA : 16'h0BBB)) begin
                failures++;
                $display("FAIL b2b_addr cyc=%0d got=%h want=%h", c, Addr,
                         (c <= 8) ? 16'h0AAA : 16'h0BBB);
            end
            if (c == 15) begin
                checks++;
                if (rsp_rdata !== 8'h96) begin
                    failures++;
                    $display("FAIL b2b_rdata got=%h want=96", rsp_rdata);
                end
            end
            tick();
            if (c == 8) begin
                cmd_valid = 1'b0;
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] exp;
        accept(2'b01, 16'h2222, 8'hC3);
        tick();
        tick();
        tick();
        checks++;
        if (nWE !== 1'b0 || nEN !== 1'b0 || io_bus !== 8'hC3) begin
            failures++;
            $display("FAIL abort_pre nWE=%b nEN=%b io=%h want nWE=0 nEN=0 io=C3", nWE, nEN, io_bus);
        end
        bi_rst = 1'b1;
        tick();
        checks++;
        if (status !== 8'hF0) begin
            failures++;
            $display("FAIL abort_pins got=%b want=%b", status, 8'hF0);
        end
        checks++;
        if (io_bus === 8'hC3 || Addr !== 16'h0 || rsp_rdata !== 8'h00) begin
            failures++;
            $display("FAIL abort_regs io=%h addr=%h rdata=%h want io!=C3 addr=0000 rdata=00",
                     io_bus, Addr, rsp_rdata);
        end
        bi_rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL abort_quiet cyc=%0d rsp_valid=%b busy=%b want 0 0", c, rsp_valid, busy);
            end
            tick();
        end
        flash_q = 8'h7E;
        accept(2'b00, 16'h0010, 8'h00);
        for (int c = 1; c <= 7; c++) begin
            exp = {!(c <= 6), !(c >= 3 && c <= 5), 1'b1, 1'b1, c == 7, 1'b0, 1'b1, 1'b0};
            checks++;
            if (status !== exp) begin
                failures++;
                $display("FAIL abort_read_pins cyc=%0d got=%b want=%b", c, status, exp);
            end
            if (c == 7) begin
                checks++;
                if (rsp_rdata !== 8'h7E || Addr !== 16'h0010) begin
                    failures++;
                    $display("FAIL abort_read_data rdata=%h addr=%h want rdata=7E addr=0010",
                             rsp_rdata, Addr);
                end
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_reset_op();
        test_reserved();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flash_access_sequencer.md
Name: flash_access_sequencer

Overview:
Parallel-flash timing engine between the SPI bus-interface command decoder and Flash_Core.
- Accepts one decoded transaction at a time (read byte, write byte, flash reset) over a valid/ready handshake.
- Generates programmable-width nEN/nRE/nWE/nReset strobes, drives Addr, and controls the bidirectional IO bus.
- Returns the read data or a completion pulse to the decoder.

Parameters:
ADDR_W, 16, flash address width
DATA_W, 8, flash data/IO width
T_SETUP, 2, cycles nEN low with Addr/IO stable before the strobe (>=1)
T_PULSE, 3, cycles nRE or nWE is held low (>=1)
T_HOLD, 1, cycles after the strobe rises with nEN/Addr/IO still held (>=1)
T_RESET, 8, cycles nReset is held low for a reset op (>=1)

Ports:
SCK  in  1  block clock; all logic on rising edge
bi_rst  in  1  synchronous, active-high reset
cmd_valid  in  1  decoder presents a command
cmd_ready  out  1  sequencer can accept; equals (state==IDLE && !bi_rst)
cmd_op  in  2  00 read, 01 write, 10 flash reset, 11 reserved
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_W  read byte; valid with rsp_valid for a read
rsp_err  out  1  set with rsp_valid for a reserved op
busy  out  1  state != IDLE
nEN  out  1  flash chip enable, active low
nRE  out  1  flash read strobe, active low
nWE  out  1  flash write strobe, active low
nReset  out  1  flash reset, active low
Addr  out  ADDR_W  flash address
IO  inout  DATA_W  flash data bus, tri-stated unless writing

Behaviour:
- Clocking and reset: single clock SCK; reset bi_rst is synchronous and active-high.
- All flash-side outputs and rsp_* are registered.
- Reset values: nEN=nRE=nWE=nReset=1, Addr=0, IO=Z, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, state=IDLE.
- Handshake: transfer on cmd_valid && cmd_ready. op/addr/wdata are latched at that edge; later input changes are ignored.
- States: IDLE, SETUP, PULSE, HOLD, RSTP, RESP. A down-counter is loaded on each entry (width clog2(max T+1)).
- IDLE: on read or write -> SETUP (cnt=T_SETUP); on reset op -> RSTP (cnt=T_RESET); on reserved op -> RESP with err=1.
- SETUP: nEN=0, Addr=latched addr; IO driven with wdata for write, Z for read. After T_SETUP cycles -> PULSE.
- PULSE: nRE=0 (read) or nWE=0 (write) for T_PULSE cycles. A read samples IO into rsp_rdata at the edge ending the last PULSE cycle. Then -> HOLD.
- HOLD: strobes high; nEN, Addr and IO (write) held for T_HOLD cycles. Then -> RESP, with nEN=1 and IO=Z on entry.
- RSTP: nReset=0, nEN=1, IO=Z for T_RESET cycles. Then -> RESP.
- RESP: rsp_valid=1 for exactly one cycle, no backpressure. rsp_err=1 only for a reserved op. Then -> IDLE.
- rsp_rdata holds its last read value until the next read completes. Write, reset and reserved ops leave it unchanged.
- Latency from the accept edge to rsp_valid high: read/write T_SETUP+T_PULSE+T_HOLD+1 (default 7); reset T_RESET+1 (9); reserved 1.
- Back-to-back commands: the next accept is possible on the cycle after RESP. Minimum two cycles of nEN high between accesses.
- IO is never driven while nRE=0. IO is driven only in SETUP/PULSE/HOLD of a write.
- nRE and nWE are never low simultaneously. Neither is low while nEN=1.
- bi_rst mid-operation: at the next edge all strobes return high, IO=Z, state=IDLE. No rsp_valid is issued for the aborted op.
- Addr keeps its last value after an access and returns to 0 only on reset.
- Any T_* parameter < 1 is a compile-time error (generate-time check).

Decomposition:
- Package flash_seq_pkg: op encodings (OP_READ, OP_WRITE, OP_RESET, OP_RSVD) and the state enum. The SPI bus interface decoder uses the same op constants.
- One sub-module, flash_seq_timer: loadable down-counter with a done flag, reused for all four phase durations.
- The FSM, output registers and IO tri-state stay in flash_access_sequencer.

Test Plan:
- Write op=01 addr=16'h1234 wdata=8'hA5 -> nEN low cycles 1-6, nWE low cycles 3-5, IO=A5 cycles 1-6, rsp_valid at cycle 7, rsp_err=0, nRE stays 1.
- Read op=00 addr=16'h00FF, flash model returns 8'h3C -> nRE low cycles 3-5, IO tri-stated throughout, rsp_valid at cycle 7 with rsp_rdata=3C.
- Reset op=10 -> nReset low cycles 1-8, nEN/nRE/nWE stay 1, rsp_valid at cycle 9.
- Reserved op=11 -> rsp_valid and rsp_err=1 at cycle 1, no flash pin toggles.
- cmd_valid held high with write then read queued -> second accept on the cycle after the first RESP; cmd_ready=0 throughout the first op; cmd_addr changes mid-op do not alter Addr.
- bi_rst asserted during PULSE of a write -> next edge nWE=nEN=1, IO=Z, no rsp_valid; a new read then completes normally in 7 cycles.
